universal_shift_register: RTL and testbench

//   Parametrised universal shift register: hold, shift-left, shift-right and parallel load.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_burst_ctrl.sv | 73 +++++++
 rtl/universal_shift_register.sv | 105 ++++++++++
 tb/tb_universal_shift_register.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ============================================================================
// usr_pkg : shared mode, FSM state and direction constants for the shift register
// Revision: 1.0
// ============================================================================
`default_nettype none

package usr_pkg;
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_BURST  = 1'b1;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
endpackage

`default_nettype wire

// File: rtl/usr_burst_ctrl.sv
// ============================================================================
// usr_burst_ctrl : auto-shift burst sequencer (FSM, shift counter, busy/done)
// Revision: 1.0
// ============================================================================
`default_nettype none

module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_start,
   input  logic             i_dir,
   input  logic [CNT_W-1:0] i_burst_len,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_shift_req,
   output logic             o_shift_dir
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir;
   logic             r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dir   <= DIR_LEFT;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (i_burst_len != '0) begin
                     r_state <= ST_BURST;
                     r_cnt   <= i_burst_len;
                     r_dir   <= i_dir;
                  end else begin
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_BURST: begin
               // en=0 freezes the count; the final shift returns to IDLE
               if (i_en) begin
                  r_cnt <= r_cnt - c_one;
                  if (r_cnt == c_one) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy      = (r_state == ST_BURST);
   assign o_done      = r_done;
   assign o_shift_req = (r_state == ST_BURST) && i_en;
   assign o_shift_dir = r_dir;

endmodule

`default_nettype wire

// File: rtl/universal_shift_register.sv
// ============================================================================
// universal_shift_register : hold/SHL/SHR/load register with burst sequencer.
// Optional USR_ROTATE_EN makes shifts circular when rot=1.   Revision: 1.0
// ============================================================================
`default_nettype none

module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             rot,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] r_q;
   logic             r_ser_out;
   logic             w_busy;
   logic             w_shift_req;
   logic             w_shift_dir;
   logic             w_rot;
   logic             w_mode_op;
   logic             w_fill_l;
   logic             w_fill_r;
   logic [WIDTH-1:0] w_shl_q;
   logic [WIDTH-1:0] w_shr_q;

`ifdef USR_ROTATE_EN
   assign w_rot = rot;
`else
   logic w_unused_rot;
   assign w_rot        = 1'b0;
   assign w_unused_rot = rot;
`endif

   usr_burst_ctrl #(
      .CNT_W       (CNT_W)
   ) u_burst_ctrl (
      .clk         (clk),
      .reset       (reset),
      .i_en        (en),
      .i_start     (start),
      .i_dir       (dir),
      .i_burst_len (burst_len),
      .o_busy      (w_busy),
      .o_done      (done),
      .o_shift_req (w_shift_req),
      .o_shift_dir (w_shift_dir)
   );

   // a start strobe in IDLE suppresses the mode op, whatever burst_len is
   assign w_mode_op = !w_busy && !start && en;
   assign w_fill_l  = w_rot ? r_q[WIDTH-1] : ser_in;
   assign w_fill_r  = w_rot ? r_q[0]       : ser_in;
   assign w_shl_q   = {r_q[WIDTH-2:0], w_fill_l};
   assign w_shr_q   = {w_fill_r, r_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q       <= '0;
         r_ser_out <= 1'b0;
      end else if (w_shift_req) begin
         if (w_shift_dir == DIR_LEFT) begin
            r_q       <= w_shl_q;
            r_ser_out <= r_q[WIDTH-1];
         end else begin
            r_q       <= w_shr_q;
            r_ser_out <= r_q[0];
         end
      end else if (w_mode_op) begin
         case (mode)
            MODE_SHL: begin
               r_q       <= w_shl_q;
               r_ser_out <= r_q[WIDTH-1];
            end
            MODE_SHR: begin
               r_q       <= w_shr_q;
               r_ser_out <= r_q[0];
            end
            MODE_LOAD: r_q <= par_in;
            default:   r_q <= r_q;
         endcase
      end
   end

   assign q       = r_q;
   assign ser_out = r_ser_out;
   assign busy    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// tb_universal_shift_register : directed and randomized bench with a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_register;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;
`ifdef USR_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [1:0]   mode;
   logic         ser_in;
   logic [W-1:0] par_in;
   logic         start;
   logic         dir;
   logic [3:0]   burst_len;
   logic         rot;
   logic [W-1:0] q;
   logic         ser_out;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_q, m_so, m_busy, m_done, m_left, m_dir;

   universal_shift_register #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
      .par_in(par_in), .start(start), .dir(dir), .burst_len(burst_len),
      .rot(rot), .q(q), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic model_shift(input int left);
      int outb, fill;
      if (left != 0) outb = (m_q >> (W - 1)) & 1;
      else           outb = m_q & 1;
      fill = (ROT_EN && rot) ? outb : int'(ser_in);
      if (left != 0) m_q = ((m_q << 1) & MASK) | fill;
      else           m_q = (m_q >> 1) | (fill << (W - 1));
      m_so = outb;
   endtask

   task automatic model_reset();
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_left = 0; m_dir = 0;
   endtask

   task automatic model_edge();
      int nd;
      nd = 0;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_busy == 0) begin
         if (start) begin
            if (burst_len != 0) begin
               m_busy = 1; m_left = int'(burst_len); m_dir = int'(dir);
            end else nd = 1;
         end else if (en) begin
            if (mode == 2'd1) model_shift(1);
            else if (mode == 2'd2) model_shift(0);
            else if (mode == 2'd3) m_q = int'(par_in);
         end
      end else if (en) begin
         model_shift(m_dir == 0 ? 1 : 0);
         m_left = m_left - 1;
         if (m_left == 0) begin m_busy = 0; nd = 1; end
      end
      m_done = nd;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic quiet();
      en = 1'b0; mode = 2'd0; start = 1'b0; rot = 1'b0; dir = 1'b0;
      burst_len = 4'd0; ser_in = 1'b0; par_in = '0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      quiet(); en = 1'b1; mode = 2'd3; par_in = v;
      tick();
      quiet();
   endtask

   task automatic test_reset();
      reset = 1'b1; quiet();
      tick(); tick();
      total++; if (q !== 8'h00 || ser_out !== 1'b0) begin bad++; $display("FAIL reset_q: q=%h so=%b want 00/0", q, ser_out); end
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, done); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load_shift();
      do_load(8'hA5);
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL load: q=%h want a5", q); end
      en = 1'b1; mode = 2'd1; ser_in = 1'b1; tick(); quiet();
      total++; if (q !== 8'h4B || ser_out !== 1'b1) begin bad++; $display("FAIL shl: q=%h so=%b want 4b/1", q, ser_out); end
      do_load(8'hA5);
      en = 1'b1; mode = 2'd2; ser_in = 1'b0; tick(); quiet();
      total++; if (q !== 8'h52 || ser_out !== 1'b1) begin bad++; $display("FAIL shr: q=%h so=%b want 52/1", q, ser_out); end
      en = 1'b1; mode = 2'd0; tick(); quiet();
      total++; if (q !== 8'h52) begin bad++; $display("FAIL hold: q=%h want 52", q); end
   endtask

   task automatic test_burst();
      logic [W-1:0] exp_q [4];
      exp_q[0] = 8'h81; exp_q[1] = 8'h02; exp_q[2] = 8'h04; exp_q[3] = 8'h08;
      do_load(8'h81);
      en = 1'b1; start = 1'b1; dir = 1'b0; burst_len = 4'd3; ser_in = 1'b0;
      for (int e = 0; e <= 3; e++) begin
         tick();
         start = 1'b0; burst_len = 4'd0; mode = 2'd3; par_in = 8'hFF;
         total++; if (q !== exp_q[e]) begin bad++; $display("FAIL burst_q%0d: q=%h want %h", e, q, exp_q[e]); end
         total++; if (busy !== (e < 3)) begin bad++; $display("FAIL burst_busy%0d: busy=%b want %b", e, busy, e < 3); end
         total++; if (done !== (e == 3)) begin bad++; $display("FAIL burst_done%0d: done=%b want %b", e, done, e == 3); end
      end
      total++; if (ser_out !== 1'b0) begin bad++; $display("FAIL burst_so: so=%b want 0", ser_out); end
      quiet(); tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL burst_done_pulse: done=%b want 0", done); end
   endtask

   task automatic test_burst_pause();
      do_load(8'h81);
      en = 1'b1; start = 1'b1; dir = 1'b1; burst_len = 4'd4; ser_in = 1'b1;
      tick();
      start = 1'b0; tick();
      total++; if (q !== 8'hC0 || ser_out !== 1'b1) begin bad++; $display("FAIL pause_first: q=%h so=%b want c0/1", q, ser_out); end
      // pause with a competing start and load request
      en = 1'b0; start = 1'b1; burst_len = 4'd2; dir = 1'b0; mode = 2'd3; par_in = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (q !== 8'hC0 || busy !== 1'b1) begin bad++; $display("FAIL pause_hold%0d: q=%h busy=%b want c0/1", i, q, busy); end
      end
      start = 1'b0; en = 1'b1;
      tick(); tick();
      total++; if (q !== 8'hF0 || busy !== 1'b1) begin bad++; $display("FAIL pause_resume: q=%h busy=%b want f0/1", q, busy); end
      tick();
      total++; if (q !== 8'hF8 || busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL pause_end: q=%h busy=%b done=%b want f8/0/1", q, busy, done); end
      quiet();
      start = 1'b1; burst_len = 4'd0; en = 1'b1; mode = 2'd1;
      tick();
      total++; if (q !== 8'hF8 || busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL len0: q=%h busy=%b done=%b want f8/0/1", q, busy, done); end
      quiet(); tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_pulse: done=%b want 0", done); end
   endtask

   task automatic test_reset_mid_burst();
      do_load(8'h81);
      en = 1'b1; start = 1'b1; burst_len = 4'd5; dir = 1'b0; ser_in = 1'b1;
      tick(); start = 1'b0; tick();
      #2 reset = 1'b1;
      model_reset();
      #1;
      total++; if (q !== 8'h00 || busy !== 1'b0 || ser_out !== 1'b0) begin bad++; $display("FAIL async_reset: q=%h busy=%b so=%b want 00/0/0", q, busy, ser_out); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin bad++; $display("FAIL post_reset%0d: done=%b busy=%b q=%h want 0/0/00", i, done, busy, q); end
      end
      quiet();
      do_load(8'h3C);
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL resume_load: q=%h want 3c", q); end
   endtask

   task automatic test_rotate();
      logic [W-1:0] exp_l, exp_r;
      exp_l = ROT_EN ? 8'h03 : 8'h02;
      exp_r = ROT_EN ? 8'hC0 : 8'h40;
      do_load(8'h81);
      en = 1'b1; mode = 2'd1; rot = 1'b1; ser_in = 1'b0; tick(); quiet();
      total++; if (q !== exp_l || ser_out !== 1'b1) begin bad++; $display("FAIL rot_shl: q=%h so=%b want %h/1", q, ser_out, exp_l); end
      do_load(8'h81);
      en = 1'b1; mode = 2'd2; rot = 1'b1; ser_in = 1'b0; tick(); quiet();
      total++; if (q !== exp_r || ser_out !== 1'b1) begin bad++; $display("FAIL rot_shr: q=%h so=%b want %h/1", q, ser_out, exp_r); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         en        = ($urandom_range(0, 3) != 0);
         mode      = 2'($urandom_range(0, 3));
         ser_in    = 1'($urandom_range(0, 1));
         par_in    = 8'($urandom_range(0, 255));
         start     = ($urandom_range(0, 7) == 0);
         dir       = 1'($urandom_range(0, 1));
         burst_len = 4'($urandom_range(0, 11));
         rot       = 1'($urandom_range(0, 1));
         tick();
         total++; if (q !== 8'(m_q) || ser_out !== 1'(m_so)) begin bad++; $display("FAIL rand_q c=%0d: q=%h so=%b want %h/%0d", c, q, ser_out, 8'(m_q), m_so); end
         total++; if (busy !== 1'(m_busy) || done !== 1'(m_done)) begin bad++; $display("FAIL rand_flags c=%0d: busy=%b done=%b want %0d/%0d", c, busy, done, m_busy, m_done); end
      end
      quiet();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_shift();
      test_burst();
      test_burst_pause();
      test_reset_mid_burst();
      test_rotate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
